// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order completion buffer in front of the
// architectural register file. Entries are allocated at issue, filled out of
// order from the CDB, and retired strictly in order at the head.
//
// Optional build macro ROB_CDB_FORWARD_EN: when defined, a CDB broadcast is
// forwarded combinationally to the operand read ports and to the head commit
// path, saving one cycle on wakeup and on retire.
module reorder_buffer #(
    parameter int ROB_WIDTH = 3,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    input  logic [REG_WIDTH-1:0] issue_arch_num,
    output logic                 issue_ready,
    output logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_data,
    input  logic [ROB_WIDTH-1:0] read_tag   [2],
    output logic                 read_ready [2],
    output logic [31:0]          read_data  [2],
    output logic                 commit,
    output logic [REG_WIDTH-1:0] commit_arch_num,
    output logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          commit_data,
    output logic [ROB_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] PTR_ONE = (ROB_WIDTH+1)'(1);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [ROB_WIDTH:0]   head_q, head_d;
    logic [ROB_WIDTH:0]   tail_q, tail_d;
    logic [DEPTH-1:0]     ready_q, ready_d;
    logic [REG_WIDTH-1:0] arch_q [DEPTH];
    logic [31:0]          data_q [DEPTH];

    logic [ROB_WIDTH-1:0] head_idx;
    logic [ROB_WIDTH-1:0] tail_idx;
    logic [ROB_WIDTH-1:0] cdb_offset;
    logic                 empty;
    logic                 full;
    logic                 issue_fire;
    logic                 cdb_hit;
    logic                 head_fwd;

    assign head_idx    = head_q[ROB_WIDTH-1:0];
    assign tail_idx    = tail_q[ROB_WIDTH-1:0];
    assign count       = tail_q - head_q;
    assign empty       = (head_q == tail_q);
    assign full        = (head_idx == tail_idx) && (head_q[ROB_WIDTH] != tail_q[ROB_WIDTH]);
    assign issue_ready = !full;
    assign issue_tag   = tail_idx;
    assign issue_fire  = issue && issue_ready;

    // A tag is occupied when its distance from head is below the occupancy.
    assign cdb_offset  = cdb_tag - head_idx;
    assign cdb_hit     = cdb_valid && ({1'b0, cdb_offset} < count);

`ifdef ROB_CDB_FORWARD_EN
    assign head_fwd    = cdb_valid && (cdb_tag == head_idx) && !empty;
`else
    assign head_fwd    = 1'b0;
`endif

    assign commit          = !empty && (ready_q[head_idx] || head_fwd);
    assign commit_arch_num = arch_q[head_idx];
    assign commit_tag      = head_idx;
    assign commit_data     = head_fwd ? cdb_data : data_q[head_idx];

    // Operand lookup for the dispatcher, with optional same-cycle CDB bypass.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            read_ready[i] = ready_q[read_tag[i]];
            read_data[i]  = data_q[read_tag[i]];
`ifdef ROB_CDB_FORWARD_EN
            if (cdb_valid && (cdb_tag == read_tag[i])) begin
                read_ready[i] = 1'b1;
                read_data[i]  = cdb_data;
            end
`endif
        end
    end

    // Next-state for pointers and ready bits; commit clear takes precedence
    // over a CDB write to the head so a forwarded retire leaves ready low.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        ready_d = ready_q;
        if (cdb_hit) begin
            ready_d[cdb_tag] = 1'b1;
        end
        if (issue_fire) begin
            ready_d[tail_idx] = 1'b0;
            tail_d            = tail_q + PTR_ONE;
        end
        if (commit) begin
            ready_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end
    end

    // Control state register; reset flushes every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    // Entry payload storage; validity is governed solely by ready_q.
    always_ff @(posedge clk) begin
        if (cdb_hit) begin
            data_q[cdb_tag] <= cdb_data;
        end
        if (issue_fire) begin
            arch_q[tail_idx] <= issue_arch_num;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: allocation, out-of-order completion,
// in-order retire, full/wrap behaviour, operand read ports and reset flush.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue;
    logic [4:0]  issue_arch_num;
    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  read_tag   [2];
    logic        read_ready [2];
    logic [31:0] read_data  [2];
    logic        commit;
    logic [4:0]  commit_arch_num;
    logic [2:0]  commit_tag;
    logic [31:0] commit_data;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .issue(issue), .issue_arch_num(issue_arch_num),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .read_tag(read_tag), .read_ready(read_ready), .read_data(read_data),
        .commit(commit), .commit_arch_num(commit_arch_num),
        .commit_tag(commit_tag), .commit_data(commit_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; issue = 1'b0; issue_arch_num = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        read_tag[0] = '0; read_tag[1] = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_issue_tag", 32'(issue_tag), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Issue arch 3, 4, 5 -> tags 0, 1, 2.
        for (int i = 0; i < 3; i++) begin
            issue = 1'b1; issue_arch_num = 5'(3 + i);
            settle();
            check("issue_tag_seq", 32'(issue_tag), 32'(i));
            tick();
        end
        issue = 1'b0;
        settle();
        check("count_after_3", 32'(count), 32'd3);
        check("no_commit_unready", 32'(commit), 32'd0);

        // Out-of-order completion: tag 1 then tag 0.
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'hAAAA;
        tick();
        cdb_tag = 3'd0; cdb_data = 32'h5555;
        settle();
`ifdef ROB_CDB_FORWARD_EN
        check("fwd_commit_tag0", 32'(commit), 32'd1);
        check("fwd_commit_data0", commit_data, 32'h5555);
        tick();
        cdb_valid = 1'b0;
        settle();
`else
        check("no_commit_before_t0", 32'(commit), 32'd0);
        tick();
        cdb_valid = 1'b0;
        settle();
        check("commit0", 32'(commit), 32'd1);
        check("commit0_tag", 32'(commit_tag), 32'd0);
        check("commit0_arch", 32'(commit_arch_num), 32'd3);
        check("commit0_data", commit_data, 32'h5555);
        tick();
`endif
        check("commit1", 32'(commit), 32'd1);
        check("commit1_tag", 32'(commit_tag), 32'd1);
        check("commit1_arch", 32'(commit_arch_num), 32'd4);
        check("commit1_data", commit_data, 32'hAAAA);
        tick();
        check("tag2_not_committed", 32'(commit), 32'd0);
        check("count_after_2_commits", 32'(count), 32'd1);

        // Fill to 8, 9th issue ignored, one retire frees a slot, wrap to tag 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue = 1'b1; issue_arch_num = 5'(i);
            tick();
        end
        settle();
        check("full_issue_ready", 32'(issue_ready), 32'd0);
        check("full_count", 32'(count), 32'd8);
        issue_arch_num = 5'd31;
        tick();
        issue = 1'b0;
        settle();
        check("ninth_ignored_count", 32'(count), 32'd8);
        check("ninth_ignored_tail", 32'(issue_tag), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h100;
`ifdef ROB_CDB_FORWARD_EN
        settle();
        check("full_retire", 32'(commit), 32'd1);
        check("full_retire_arch", 32'(commit_arch_num), 32'd0);
        tick();
        cdb_valid = 1'b0;
`else
        tick();
        cdb_valid = 1'b0;
        settle();
        check("full_retire", 32'(commit), 32'd1);
        check("full_retire_arch", 32'(commit_arch_num), 32'd0);
        tick();
`endif
        settle();
        check("freed_issue_ready", 32'(issue_ready), 32'd1);
        check("freed_count", 32'(count), 32'd7);
        check("wrap_tag", 32'(issue_tag), 32'd0);
        issue = 1'b1; issue_arch_num = 5'd9;
        tick();
        issue = 1'b0;
        settle();
        check("refill_count", 32'(count), 32'd8);
        check("refill_issue_ready", 32'(issue_ready), 32'd0);

        // Fill 8, complete in reverse order, then 8 back-to-back retires.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue = 1'b1; issue_arch_num = 5'(10 + i);
            tick();
        end
        issue = 1'b0;
        cdb_valid = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            cdb_tag = 3'(i); cdb_data = 32'h1000 + 32'(i);
            tick();
        end
        cdb_tag = 3'd0; cdb_data = 32'h1000;
        settle();
`ifdef ROB_CDB_FORWARD_EN
        check("b2b_commit_k0", 32'(commit), 32'd1);
        check("b2b_tag_k0", 32'(commit_tag), 32'd0);
        tick();
        cdb_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
`else
        check("b2b_wait_t0", 32'(commit), 32'd0);
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
`endif
            settle();
            check("b2b_commit", 32'(commit), 32'd1);
            check("b2b_tag", 32'(commit_tag), 32'(k));
            check("b2b_arch", 32'(commit_arch_num), 32'(10 + k));
            check("b2b_data", commit_data, 32'h1000 + 32'(k));
            if (k == 1) begin
                check("b2b_count_pre", 32'(count), 32'd7);
                check("b2b_issue_ready", 32'(issue_ready), 32'd1);
                check("b2b_issue_tag", 32'(issue_tag), 32'd0);
                issue = 1'b1; issue_arch_num = 5'd20;
            end
            if (k == 2) begin
                check("b2b_count_const", 32'(count), 32'd7);
            end
            tick();
            issue = 1'b0;
        end
        settle();
        check("b2b_done_commit", 32'(commit), 32'd0);
        check("b2b_done_count", 32'(count), 32'd1);

        // Operand read port wakeup.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue = 1'b1; issue_arch_num = 5'(i);
            tick();
        end
        issue = 1'b0;
        read_tag[0] = 3'd2; read_tag[1] = 3'd0;
        settle();
        check("read_unready", 32'(read_ready[0]), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h1234;
        settle();
`ifdef ROB_CDB_FORWARD_EN
        check("read_fwd_ready", 32'(read_ready[0]), 32'd1);
        check("read_fwd_data", read_data[0], 32'h1234);
`else
        check("read_same_cycle", 32'(read_ready[0]), 32'd0);
`endif
        tick();
        cdb_valid = 1'b0;
        settle();
        check("read_ready", 32'(read_ready[0]), 32'd1);
        check("read_data", read_data[0], 32'h1234);
        check("read_other_port", 32'(read_ready[1]), 32'd0);

        // Reset with 5 in flight, concurrent CDB and issue are ignored.
        for (int i = 0; i < 2; i++) begin
            issue = 1'b1; issue_arch_num = 5'(i);
            tick();
        end
        settle();
        check("inflight_count", 32'(count), 32'd5);
        reset = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'hDEAD;
        tick();
        reset = 1'b0; issue = 1'b0; cdb_valid = 1'b0;
        settle();
        check("flush_count", 32'(count), 32'd0);
        check("flush_commit", 32'(commit), 32'd0);
        check("flush_issue_tag", 32'(issue_tag), 32'd0);
        check("flush_issue_ready", 32'(issue_ready), 32'd1);

        // Stale CDB to tag 3 with only tag 0 occupied is dropped.
        issue = 1'b1; issue_arch_num = 5'd7;
        tick();
        issue = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'hBEEF;
        tick();
        cdb_valid = 1'b0;
        read_tag[0] = 3'd3;
        settle();
        check("stale_dropped", 32'(read_ready[0]), 32'd0);
        check("stale_no_commit", 32'(commit), 32'd0);
        check("stale_count", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order completion buffer upstream of the architectural register file.
- At issue it allocates a tag per instruction. It captures results broadcast on the CDB, possibly out of order.
- It retires entries strictly in order, driving the register file's commit, commit_arch_num, commit_tag and commit_data inputs.
- It also supplies the operand read ports that the dispatcher uses when a register file entry is marked not-valid.

Parameters:
ROB_WIDTH, 3, log2 of entry count (default 8 entries); tag width.
REG_WIDTH, 5, architectural register number width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high; flushes buffer
issue  input  1  allocate one entry this cycle (must only be asserted with issue_ready)
issue_arch_num  input  REG_WIDTH  destination register of issued instruction
issue_ready  output  1  buffer not full
issue_tag  output  ROB_WIDTH  tag that the current issue receives (= tail)
cdb_valid  input  1  result broadcast valid
cdb_tag  input  ROB_WIDTH  tag of broadcast result
cdb_data  input  32  broadcast result
read_tag[2]  input  ROB_WIDTH  operand tags to look up
read_ready[2]  output  1  entry for read_tag holds its result
read_data[2]  output  32  result stored for read_tag
commit  output  1  head entry retires this cycle
commit_arch_num  output  REG_WIDTH  destination of head entry
commit_tag  output  ROB_WIDTH  head tag
commit_data  output  32  head result
count  output  ROB_WIDTH+1  occupied entries (debug/perf)

Behaviour:
- State:
  - head and tail pointers, each ROB_WIDTH+1 bits; the extra MSB distinguishes full from empty.
  - Per entry: arch_num, ready, data.
- Pointer-derived signals:
  - count = tail - head, modulo 2^(ROB_WIDTH+1).
  - empty: head == tail.
  - full: index bits equal, MSBs differ.
- Reset, synchronous: head = tail = 0; all entry ready = 0.
  - Outputs after reset: commit = 0, issue_ready = 1, issue_tag = 0, count = 0.
  - Reset mid-operation discards all in-flight entries. Any CDB or issue in the same cycle is ignored.
- Issue:
  - issue_ready = !full. This is registered-state based only; a same-cycle commit does not free a slot for a same-cycle issue.
  - On issue && issue_ready: entry[tail].arch_num <= issue_arch_num, entry[tail].ready <= 0, tail++.
  - Pointers wrap naturally at 2^ROB_WIDTH.
  - issue while full is ignored.
- CDB capture:
  - On cdb_valid, if cdb_tag lies in the occupied range [head, tail): entry.ready <= 1, entry.data <= cdb_data.
  - A tag outside the occupied range is dropped.
  - CDB to the entry being issued in the same cycle is impossible by construction; issue wins.
- Commit:
  - Combinational: commit = !empty && entry[head].ready.
  - commit_arch_num, commit_tag and commit_data come from entry[head]. commit_tag = head index.
  - On commit: head++, entry[head].ready <= 0.
  - At most one commit per cycle.
- Latency:
  - A CDB write to tag T makes read_ready visible the next cycle.
  - If T is head, commit asserts the next cycle.
  - Issue-to-commit is at least 2 cycles.
- Simultaneous issue + commit: both take effect and count is unchanged. When empty, a same-cycle issue cannot commit.
- Read ports: combinational; read_ready/read_data = entry[read_tag].ready/data. The result for an unoccupied tag is don't-care.

Optional Feature:
- Macro ROB_CDB_FORWARD_EN.
- Defined:
  - If cdb_valid && cdb_tag == read_tag[i], then read_ready[i] = 1 and read_data[i] = cdb_data in the same cycle.
  - If cdb_valid && cdb_tag == head && !empty, commit asserts in the same cycle with commit_data = cdb_data.
  - This saves one cycle on operand wakeup and on retire.
- Undefined: stored values only; one extra cycle as described under Latency.

Test Plan:
- Reset, then issue arch 3, 4, 5 on consecutive cycles -> issue_tag 0, 1, 2. count = 3, commit = 0.
- CDB tag 1 = 0xAAAA, then tag 0 = 0x5555 -> the cycle after tag 0: commit with tag 0, arch 3, data 0x5555. Next cycle: commit with tag 1, arch 4, data 0xAAAA. Tag 2 is not committed.
- Issue 8 times without CDB -> issue_ready = 0 and count = 8. A 9th issue is ignored. CDB tag 0 -> one commit, then issue_ready = 1. A new issue gets tag 0 (wrap).
- Fill 8 entries, complete all via CDB -> 8 back-to-back commits with tags 0..7 in order. An issue during those commits keeps count constant.
- read_tag[0] = 2 while unready -> read_ready = 0. After CDB tag 2 = 0x1234 -> read_ready = 1, data = 0x1234 next cycle (same cycle with ROB_CDB_FORWARD_EN).
- Reset asserted with 5 entries in flight and cdb_valid high -> next cycle count = 0, commit = 0, issue_tag = 0. A stale CDB to tag 3 afterwards is ignored.
